// File: rtl/instruction_buffer_lvl3_pkg.sv
// Shared constants, entry layout and pointer helper for the decode-to-execute instruction buffer.
package ibuf_pkg;

  localparam int unsigned IBUF_DATA_W = 32;
  localparam int unsigned IBUF_DEPTH  = 8;

  typedef struct packed {
    logic        is_long;
    logic [31:0] data;
  } ibuf_entry_t;

  // Ring pointer advance; depth need not be a power of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/instruction_buffer_lvl3_storage.sv
// Payload array for the instruction buffer: one write port, one asynchronous read port, no reset.
module ibuf_storage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W:0]          rdata
);

  logic [DATA_W:0] mem_q [DEPTH];

  // Write the pushed entry; contents are only meaningful between push and pop.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Head entry is visible in the same cycle so the issue path has zero latency.
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/instruction_buffer_lvl3.sv
// Decode-to-execute instruction buffer: payload FIFO with empty-buffer bypass for short
// instructions, long-instruction execute hold, synchronous flush, almost-full and sticky overflow.
module instruction_buffer_lvl3
  import ibuf_pkg::*;
#(
  parameter int unsigned DATA_W       = IBUF_DATA_W,
  parameter int unsigned DEPTH        = IBUF_DEPTH,
  parameter int unsigned AFULL_THRESH = DEPTH - 1,
  parameter int unsigned LONG_LAT     = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_is_long,
  output logic                       in_stall,
  input  logic                       exec_busy,
  input  logic                       exec_will_free_next,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_is_long,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       overflow_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LC_W  = (LONG_LAT > 1) ? $clog2(LONG_LAT) : 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LC_W-1:0]  long_cnt_q, long_cnt_d;
  logic             overflow_q, overflow_d;

  logic             issue_ok_s, stall_s, bypass_s, push_s, pop_s, issue_s;
  logic             empty_s, full_s;
  logic [DATA_W:0]  head_s, wdata_s;

  ibuf_storage #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_q),
    .wdata (wdata_s),
    .raddr (rd_ptr_q),
    .rdata (head_s)
  );

  // Issue/accept decisions; stall uses registered count so a same-cycle pop never releases it.
  always_comb begin
    empty_s    = (count_q == CNT_W'(0));
    full_s     = (count_q == CNT_W'(DEPTH));
    issue_ok_s = (~exec_busy | exec_will_free_next) & (long_cnt_q == LC_W'(0)) & ~flush;
    stall_s    = full_s | flush;
    bypass_s   = in_valid & ~in_is_long & empty_s & issue_ok_s;
    push_s     = in_valid & ~stall_s & ~bypass_s;
    pop_s      = ~empty_s & issue_ok_s;
    issue_s    = pop_s | bypass_s;
    wdata_s    = {in_is_long, in_data};
  end

  // Output drive; while reset is held the buffer looks stalled and idle.
  always_comb begin
    in_stall     = stall_s | ~reset_n;
    out_valid    = issue_s & reset_n;
    out_data     = empty_s ? in_data    : head_s[DATA_W-1:0];
    out_is_long  = empty_s ? in_is_long : head_s[DATA_W];
    count        = count_q;
    almost_full  = (count_q >= CNT_W'(AFULL_THRESH));
    overflow_err = overflow_q;
  end

  // Next-state for occupancy, pointers, long hold and overflow flag; flush clears all but overflow.
  always_comb begin
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    long_cnt_d = long_cnt_q;
    overflow_d = overflow_q | (in_valid & full_s & ~flush);
    if (flush) begin
      count_d    = CNT_W'(0);
      rd_ptr_d   = PTR_W'(0);
      wr_ptr_d   = PTR_W'(0);
      long_cnt_d = LC_W'(0);
    end else begin
      if (push_s) begin
        wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (issue_s & out_is_long & (LONG_LAT > 1)) begin
        long_cnt_d = LC_W'(LONG_LAT - 1);
      end else if (long_cnt_q != LC_W'(0)) begin
        long_cnt_d = long_cnt_q - LC_W'(1);
      end else begin
        long_cnt_d = LC_W'(0);
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= CNT_W'(0);
      rd_ptr_q   <= PTR_W'(0);
      wr_ptr_q   <= PTR_W'(0);
      long_cnt_q <= LC_W'(0);
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      long_cnt_q <= long_cnt_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
